ux607_ctrlreg_arb: RTL and testbench

Two-port write arbiter and sequencer for a WIDTH-bit asynchronously reset control register, used by the ux607 peripherals. Requester 0 is the bus-side register write path. Requester 1 is a hardware event source, for example a status or interrupt-clear engine. The block arbitrates between them round-robin, applies WRITE/SET/CLEAR/TOGGLE operations as a read-modify-write on the stored value, and drives the register enable. The resulting q value is exported to the peripheral datapath.

---
 rtl/ux607_ctrlreg_pkg.sv | 26 ++
 rtl/ux607_AsyncResetReg.sv | 17 +
 rtl/ux607_AsyncResetRegVec_1.sv | 18 +
 rtl/ux607_ctrlreg_arb.sv | 100 ++++++++++
 tb/tb_ux607_ctrlreg_arb.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ux607_ctrlreg_pkg.sv
// Shared types and the read-modify-write rule for the ux607 control-register arbiter.
package ux607_ctrlreg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLR   = 2'd2,
        OP_TGL   = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    // Every op is bitwise, so the rule is written per bit and stays WIDTH-agnostic.
    function automatic logic next_val(op_e op, logic q, logic d);
        case (op)
            OP_WRITE: return d;
            OP_SET:   return q | d;
            OP_CLR:   return q & ~d;
            default:  return q ^ d;
        endcase
    endfunction

endpackage

// File: rtl/ux607_AsyncResetReg.sv
// Single asynchronously reset flop with load enable.
module ux607_AsyncResetReg #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/ux607_AsyncResetRegVec_1.sv
// Existing 5-bit asynchronously reset register vector with load enable.
module ux607_AsyncResetRegVec_1 #(
    parameter logic [4:0] RESET_VAL = 5'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_en,
    input  logic [4:0] io_d,
    output logic [4:0] io_q
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      io_q <= RESET_VAL;
        else if (io_en) io_q <= io_d;
    end

endmodule

// File: rtl/ux607_ctrlreg_arb.sv
// Round-robin two-port write arbiter that sequences WRITE/SET/CLEAR/TOGGLE
// operations onto an asynchronously reset control register.
module ux607_ctrlreg_arb
    import ux607_ctrlreg_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [1:0]       io_req0_op,
    input  logic [WIDTH-1:0] io_req0_data,
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [1:0]       io_req1_op,
    input  logic [WIDTH-1:0] io_req1_data,
    input  logic             io_lock,
    output logic [WIDTH-1:0] io_q,
    output logic             io_done,
    output logic             io_done_src,
    output logic             io_changed,
    output logic             io_busy
);

    state_e           state;
    logic             last;
    logic             held_src;
    op_e              held_op;
    logic [WIDTH-1:0] held_data;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nv;
    logic             apply, elig0, elig1, acc0, acc1;

    assign apply = (state == ST_APPLY);
    assign elig0 = io_req0_valid;
    assign elig1 = io_req1_valid & ~io_lock;

    // last == 1 means requester 1 was served last, so requester 0 wins a tie.
    assign io_req0_ready = ~apply & ~(elig1 & ~last);
    assign io_req1_ready = ~apply & ~io_lock & ~(elig0 & last);

    assign acc0 = io_req0_valid & io_req0_ready;
    assign acc1 = io_req1_valid & io_req1_ready;

    always_comb begin
        nv = '0;
        for (int i = 0; i < WIDTH; i++) nv[i] = next_val(held_op, q[i], held_data[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            held_src  <= 1'b0;
            held_op   <= OP_WRITE;
            held_data <= '0;
        end else if (apply) begin
            state <= ST_IDLE;
        end else if (acc0 || acc1) begin
            state     <= ST_APPLY;
            held_src  <= ~acc0;
            held_op   <= op_e'(acc0 ? io_req0_op : io_req1_op);
            held_data <= acc0 ? io_req0_data : io_req1_data;
            last      <= ~acc0;
        end
    end

    assert property (@(posedge clock) disable iff (reset) !(acc0 && acc1));

    assign io_q        = q;
    assign io_busy     = apply;
    assign io_done     = apply;
    assign io_done_src = apply & held_src;
    assign io_changed  = apply & (nv != q);

    generate
        if (WIDTH == 5) begin : g_vec
            ux607_AsyncResetRegVec_1 #(.RESET_VAL(RESET_VAL)) u_reg (
                .clock (clock),
                .reset (reset),
                .io_en (apply),
                .io_d  (nv),
                .io_q  (q)
            );
        end else begin : g_bits
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                ux607_AsyncResetReg #(.RESET_VAL(RESET_VAL[i])) u_bit (
                    .clk (clock),
                    .rst (reset),
                    .en  (apply),
                    .d   (nv[i]),
                    .q   (q[i])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_ux607_ctrlreg_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ux607_ctrlreg_arb;

    logic       clock, reset;
    logic       io_req0_valid, io_req0_ready, io_req1_valid, io_req1_ready;
    logic [1:0] io_req0_op, io_req1_op;
    logic [4:0] io_req0_data, io_req1_data, io_q;
    logic       io_lock, io_done, io_done_src, io_changed, io_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       src;
        logic [1:0] op;
        logic [4:0] d;
    } item_t;

    item_t      pend[$];
    logic [4:0] mq;
    logic       mlast;

    logic s_r0, s_r1, s_done, s_src, s_changed;
    logic srcs[$];

    ux607_ctrlreg_arb #(.WIDTH(5), .RESET_VAL(5'h00)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req0_valid(io_req0_valid),
        .io_req0_ready(io_req0_ready),
        .io_req0_op   (io_req0_op),
        .io_req0_data (io_req0_data),
        .io_req1_valid(io_req1_valid),
        .io_req1_ready(io_req1_ready),
        .io_req1_op   (io_req1_op),
        .io_req1_data (io_req1_data),
        .io_lock      (io_lock),
        .io_q         (io_q),
        .io_done      (io_done),
        .io_done_src  (io_done_src),
        .io_changed   (io_changed),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] apply_op(logic [1:0] op, logic [4:0] q, logic [4:0] d);
        case (op)
            2'd0:    return d;
            2'd1:    return q | d;
            2'd2:    return q & ~d;
            default: return q ^ d;
        endcase
    endfunction

    task automatic model_reset();
        mq    = 5'h00;
        mlast = 1'b1;
        pend.delete();
    endtask

    // One clock cycle: drive after the falling edge, compare against the model,
    // then let the rising edge commit and advance the model.
    task automatic step(input logic v0, input logic [1:0] op0, input logic [4:0] d0,
                        input logic v1, input logic [1:0] op1, input logic [4:0] d1,
                        input logic lk);
        logic       idle, e0, e1, x_r0, x_r1, x_src;
        logic [4:0] nv;
        item_t      it;
        io_req0_valid = v0; io_req0_op = op0; io_req0_data = d0;
        io_req1_valid = v1; io_req1_op = op1; io_req1_data = d1;
        io_lock       = lk;
        #1;
        idle  = (pend.size() == 0);
        e0    = v0;
        e1    = v1 && !lk;
        x_r0  = idle && !(e1 && !mlast);
        x_r1  = idle && !lk && !(e0 && mlast);
        nv    = mq;
        x_src = 1'b0;
        if (!idle) begin
            nv    = apply_op(pend[0].op, mq, pend[0].d);
            x_src = pend[0].src;
        end
        check("ready0",   32'(io_req0_ready), 32'(x_r0));
        check("ready1",   32'(io_req1_ready), 32'(x_r1));
        check("done",     32'(io_done),       32'(!idle));
        check("done_src", 32'(io_done_src),   32'(x_src));
        check("changed",  32'(io_changed),    32'(!idle && nv != mq));
        check("busy",     32'(io_busy),       32'(!idle));
        check("q",        32'(io_q),          32'(mq));
        s_r0 = io_req0_ready; s_r1 = io_req1_ready;
        s_done = io_done; s_src = io_done_src; s_changed = io_changed;
        @(posedge clock);
        if (!idle) begin
            mq = nv;
            void'(pend.pop_front());
        end else if (v0 && x_r0) begin
            it = '{1'b0, op0, d0};
            pend.push_back(it);
            mlast = 1'b0;
        end else if (v1 && x_r1) begin
            it = '{1'b1, op1, d1};
            pend.push_back(it);
            mlast = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 5'h00, 1'b0, 2'd0, 5'h00, 1'b0);
    endtask

    task automatic op0(input logic [1:0] op, input logic [4:0] d);
        step(1'b1, op, d, 1'b0, 2'd0, 5'h00, 1'b0);
        idle_step();
    endtask

    initial begin
        reset = 1'b1;
        io_req0_valid = 1'b0; io_req0_op = 2'd0; io_req0_data = 5'h00;
        io_req1_valid = 1'b0; io_req1_op = 2'd0; io_req1_data = 5'h00;
        io_lock = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_q",        32'(io_q),          32'h00);
        check("rst_busy",     32'(io_busy),       32'h0);
        check("rst_done",     32'(io_done),       32'h0);
        check("rst_done_src", 32'(io_done_src),   32'h0);
        check("rst_changed",  32'(io_changed),    32'h0);
        check("rst_ready0",   32'(io_req0_ready), 32'h1);
        check("rst_ready1",   32'(io_req1_ready), 32'h1);

        // First write and its apply cycle
        step(1'b1, 2'd0, 5'h15, 1'b0, 2'd0, 5'h00, 1'b0);
        check("tp_wr_ready0", 32'(s_r0), 32'h1);
        idle_step();
        check("tp_wr_done",    32'(s_done),    32'h1);
        check("tp_wr_src",     32'(s_src),     32'h0);
        check("tp_wr_changed", 32'(s_changed), 32'h1);
        check("tp_wr_q",       32'(io_q),      32'h15);

        op0(2'd1, 5'h0A); check("tp_set_q", 32'(io_q), 32'h1F);
        op0(2'd2, 5'h11); check("tp_clr_q", 32'(io_q), 32'h0E);
        op0(2'd3, 5'h1F); check("tp_tgl_q", 32'(io_q), 32'h11);
        op0(2'd0, 5'h11);
        check("tp_same_changed", 32'(s_changed), 32'h0);
        check("tp_same_q",       32'(io_q),      32'h11);

        // Lock holds requester 1 off; release lets it in next cycle
        repeat (3) begin
            step(1'b0, 2'd0, 5'h00, 1'b1, 2'd0, 5'h03, 1'b1);
            check("tp_lock_ready1", 32'(s_r1), 32'h0);
            check("tp_lock_q",      32'(io_q), 32'h11);
        end
        step(1'b0, 2'd0, 5'h00, 1'b1, 2'd0, 5'h03, 1'b0);
        check("tp_unlock_ready1", 32'(s_r1), 32'h1);
        idle_step();
        check("tp_unlock_q", 32'(io_q), 32'h03);

        // Both held valid: grants alternate starting with requester 0
        srcs.delete();
        repeat (8) begin
            step(1'b1, 2'd0, 5'h01, 1'b1, 2'd0, 5'h02, 1'b0);
            if (s_done) begin
                srcs.push_back(s_src);
                check("tp_alt_q", 32'(io_q), s_src ? 32'h02 : 32'h01);
            end
        end
        check("tp_alt_count", 32'(srcs.size()), 32'd4);
        for (int k = 0; k < srcs.size(); k++)
            check("tp_alt_src", 32'(srcs[k]), 32'(k % 2));

        // Lock rising during requester 1's apply does not cancel it
        step(1'b0, 2'd0, 5'h00, 1'b1, 2'd0, 5'h0C, 1'b0);
        step(1'b0, 2'd0, 5'h00, 1'b1, 2'd0, 5'h0C, 1'b1);
        check("tp_lockapply_done", 32'(s_done), 32'h1);
        check("tp_lockapply_src",  32'(s_src),  32'h1);
        idle_step();
        check("tp_lockapply_q", 32'(io_q), 32'h0C);

        // Reset in the middle of an apply drops the operation
        step(1'b1, 2'd0, 5'h1F, 1'b0, 2'd0, 5'h00, 1'b0);
        io_req0_valid = 1'b0;
        #1;
        check("tp_midrst_pre_busy", 32'(io_busy), 32'h1);
        reset = 1'b1;
        #1;
        check("tp_midrst_q",    32'(io_q),    32'h00);
        check("tp_midrst_done", 32'(io_done), 32'h0);
        check("tp_midrst_busy", 32'(io_busy), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(1'b1, 2'd0, 5'h07, 1'b1, 2'd0, 5'h18, 1'b0);
        check("tp_midrst_tie_r0", 32'(s_r0), 32'h1);
        check("tp_midrst_tie_r1", 32'(s_r1), 32'h0);
        idle_step();
        check("tp_midrst_tie_q", 32'(io_q), 32'h07);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
